simple_processor_core: RTL and testbench



---
 rtl/simple_processor_pkg.sv | 44 ++++
 rtl/simple_processor_if.sv | 14 +
 rtl/simple_processor_alu.sv | 23 ++
 rtl/simple_processor_core.sv | 118 +++++++++++
 tb/tb_simple_processor_core.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/simple_processor_pkg.sv
// Shared constants, state encoding and decode helpers for the simple processor.
package simple_processor_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned OPC_W    = 3;
  localparam int unsigned IMM_W    = 9;
  localparam int unsigned MVT_W    = 8;

  // Instruction field bit positions
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 13;
  localparam int unsigned IMM_BIT  = 12;
  localparam int unsigned RX_MSB   = 11;
  localparam int unsigned RX_LSB   = 9;
  localparam int unsigned IMM_MSB  = 8;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned RY_MSB   = 2;
  localparam int unsigned RY_LSB   = 0;
  localparam int unsigned MVT_MSB  = 7;
  localparam int unsigned MVT_LSB  = 0;

  localparam logic [OPC_W-1:0] OP_MV  = 3'b000;
  localparam logic [OPC_W-1:0] OP_MVT = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b011;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  // Sign-extend the 9-bit immediate to the data width
  function automatic logic [DATA_W-1:0] sext_imm9(input logic [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  // Opcodes 100-111 are reserved and never write the register file
  function automatic logic op_writes_reg(input logic [OPC_W-1:0] op);
    return (op[OPC_W-1] == 1'b0);
  endfunction

endpackage

// File: rtl/simple_processor_if.sv
// Instruction handshake between an instruction source and the core.
interface simple_processor_if;
  import simple_processor_pkg::*;

  logic              run;
  logic [DATA_W-1:0] DIN;
  logic              done;

  // Instruction source side
  modport master (output run, output DIN, input done);
  // Processor core side
  modport slave  (input run, input DIN, output done);

endinterface

// File: rtl/simple_processor_alu.sv
// Combinational result generator for mv, mvt, add and sub.
module simple_processor_alu
  import simple_processor_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OPC_W-1:0]  op,
  output logic [DATA_W-1:0] result
);

  // Select the result; reserved opcodes pass a through (never written back)
  always_comb begin
    result = a;
    unique case (op)
      OP_MV:   result = b;
      OP_MVT:  result = {b[MVT_W-1:0], (DATA_W-MVT_W)'(0)};
      OP_ADD:  result = DATA_W'(a + b);
      OP_SUB:  result = DATA_W'(a - b);
      default: result = a;
    endcase
  end

endmodule

// File: rtl/simple_processor_core.sv
// Two-cycle single-bus processor: IDLE captures the instruction, EXEC writes rX.
module simple_processor_core
  import simple_processor_pkg::*;
(
  input  logic               clk_50MHz,
  input  logic               reset,
  simple_processor_if.slave  bus
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] ir_d;

  // General registers r0-r7, kept under this name for hierarchical access
  logic [DATA_W-1:0] r [0:NUM_REGS-1];

  logic [OPC_W-1:0]  opcode;
  logic              imm_flag;
  logic [REG_AW-1:0] rx;
  logic [REG_AW-1:0] ry;
  logic [IMM_W-1:0]  imm9;
  logic [MVT_W-1:0]  mvt_byte;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic              done_c;
  logic              wr_en_c;

  // State register
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; run is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!bus.run) state_d = S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only (Moore)
  always_comb begin
    done_c  = 1'b0;
    wr_en_c = 1'b0;
    if (state_q == S_EXEC) begin
      done_c  = 1'b1;
      wr_en_c = op_writes_reg(opcode);
    end
  end

  assign bus.done = done_c;

  // Instruction capture: DIN is latched only on the IDLE start request
  always_comb begin
    ir_d = ir_q;
    if ((state_q == S_IDLE) && !bus.run) begin
      ir_d = bus.DIN;
    end
  end

  // Instruction register
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      ir_q <= '0;
    end else begin
      ir_q <= ir_d;
    end
  end

  // Field decode from the captured instruction
  always_comb begin
    opcode   = ir_q[OPC_MSB:OPC_LSB];
    imm_flag = ir_q[IMM_BIT];
    rx       = ir_q[RX_MSB:RX_LSB];
    ry       = ir_q[RY_MSB:RY_LSB];
    imm9     = ir_q[IMM_MSB:IMM_LSB];
    mvt_byte = ir_q[MVT_MSB:MVT_LSB];
  end

  // Operand selection; both operands read the pre-write register values
  always_comb begin
    op_a = r[rx];
    if (opcode == OP_MVT) begin
      op_b = {(DATA_W-MVT_W)'(0), mvt_byte};
    end else if (imm_flag) begin
      op_b = sext_imm9(imm9);
    end else begin
      op_b = r[ry];
    end
  end

  simple_processor_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (opcode),
    .result (alu_result)
  );

  // Register file write at the closing edge of EXEC; reset wins
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r[i] <= '0;
      end
    end else if (wr_en_c) begin
      r[rx] <= alu_result;
    end
  end

endmodule

// File: tb/tb_simple_processor_core.sv
// Directed bench for simple_processor_core with hand-computed register values.
module tb_simple_processor_core;

  logic clk_50MHz;
  logic reset;
  int   checks;
  int   errors;
  int   done_cnt;

  simple_processor_if bus ();

  simple_processor_core dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .bus       (bus)
  );

  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Synchronous reset, then verify the reset state at the following negedge
  task automatic do_reset();
    @(negedge clk_50MHz);
    reset   = 1'b1;
    bus.run = 1'b1;
    bus.DIN = 16'h0000;
    @(negedge clk_50MHz);
    reset = 1'b0;
    chk("reset_done", 16'(bus.done), 16'h0000);
    chk("reset_r0", dut.r[0], 16'h0000);
    chk("reset_r7", dut.r[7], 16'h0000);
    done_cnt = 0;
  endtask

  // One instruction: run low for a cycle, then run high during EXEC with junk on DIN
  task automatic exec(input logic [15:0] din);
    bus.run = 1'b0;
    bus.DIN = din;
    @(negedge clk_50MHz);
    chk("done_hi", 16'(bus.done), 16'h0001);
    if (bus.done === 1'b1) done_cnt++;
    bus.run = 1'b1;
    bus.DIN = ~din;
    @(negedge clk_50MHz);
    chk("done_lo", 16'(bus.done), 16'h0000);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    reset    = 1'b1;
    bus.run  = 1'b1;
    bus.DIN  = 16'h0000;
    repeat (2) @(negedge clk_50MHz);

    // 1: mv/mv/add
    do_reset();
    exec(16'h1001);
    chk("s1_r0_mv", dut.r[0], 16'h0001);
    exec(16'h1202);
    exec(16'h4001);
    chk("s1_r0", dut.r[0], 16'h0003);
    chk("s1_r1", dut.r[1], 16'h0002);
    chk("s1_done_cnt", 16'(done_cnt), 16'd3);

    // 2: negative immediate and wrap
    do_reset();
    exec(16'h11FF);
    chk("s2_r0_neg", dut.r[0], 16'hFFFF);
    exec(16'h1202);
    exec(16'h4001);
    chk("s2_r0_wrap", dut.r[0], 16'h0001);

    // 3: subtract register
    do_reset();
    exec(16'h1001);
    exec(16'h13FE);
    chk("s3_r1", dut.r[1], 16'hFFFE);
    exec(16'h6001);
    chk("s3_r0", dut.r[0], 16'h0003);
    do_reset();
    exec(16'h11FF);
    exec(16'h13FE);
    exec(16'h6001);
    chk("s3b_r0", dut.r[0], 16'h0001);

    // 4: subtract immediate, move-top
    do_reset();
    exec(16'h11FF);
    exec(16'h71FE);
    chk("s4_r0_sub", dut.r[0], 16'h0001);
    exec(16'h30FF);
    chk("s4_r0_mvt", dut.r[0], 16'hFF00);

    // 5: run held low, back-to-back; add r0,r0 uses old value twice
    do_reset();
    bus.run = 1'b0;
    bus.DIN = 16'h1005;
    @(negedge clk_50MHz);
    chk("s5_done1", 16'(bus.done), 16'h0001);
    bus.DIN = 16'h4000;
    @(negedge clk_50MHz);
    chk("s5_idle1", 16'(bus.done), 16'h0000);
    chk("s5_r0_a", dut.r[0], 16'h0005);
    @(negedge clk_50MHz);
    chk("s5_done2", 16'(bus.done), 16'h0001);
    bus.run = 1'b1;
    @(negedge clk_50MHz);
    chk("s5_idle2", 16'(bus.done), 16'h0000);
    chk("s5_r0_b", dut.r[0], 16'h000A);

    // 6: reset during EXEC suppresses the write
    do_reset();
    bus.run = 1'b0;
    bus.DIN = 16'h1007;
    @(negedge clk_50MHz);
    chk("s6_done", 16'(bus.done), 16'h0001);
    bus.run = 1'b1;
    reset   = 1'b1;
    @(negedge clk_50MHz);
    reset = 1'b0;
    chk("s6_done_rst", 16'(bus.done), 16'h0000);
    chk("s6_r0_rst", dut.r[0], 16'h0000);
    @(negedge clk_50MHz);
    chk("s6_idle", 16'(bus.done), 16'h0000);

    // Reserved opcodes pulse done but do not write
    exec(16'h1001);
    exec(16'h8000);
    chk("s6_rsv_r0", dut.r[0], 16'h0001);
    exec(16'h9E05);
    chk("s6_rsv_r7", dut.r[7], 16'h0000);
    chk("s6_rsv_cnt", 16'(done_cnt), 16'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
